// File: rtl/fmeas_sequencer.sv
// fmeas_sequencer: runs one ring-oscillator frequency-measurement round.
// It clears all counters, opens a shared gate window, waits for the ROS-domain
// synchronisers to settle, then latches and streams each enabled counter in turn
// through the readout shift register. The FSM state is exposed on state_dbg.
module fmeas_sequencer #(
  parameter int COUNTER_LENGTH = 20,
  parameter int GATE_CYCLES    = 4096,
  parameter int CLEAR_CYCLES   = 4,
  parameter int SETTLE_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       start,
  input  logic       abort,
  input  logic       continuous,
  input  logic [3:0] ros_mask,
  output logic       gate,
  output logic       ctr_reset,
  output logic       latch_counter,
  output logic [1:0] counter_select,
  output logic       frame_valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] round_count,
  output logic [2:0] state_dbg
);

  // One frame carries the counter value plus a 4-bit header/trailer.
  localparam int FRAME_CYCLES = COUNTER_LENGTH + 4;
  localparam int MAX_A   = (GATE_CYCLES > FRAME_CYCLES) ? GATE_CYCLES : FRAME_CYCLES;
  localparam int MAX_B   = (CLEAR_CYCLES > SETTLE_CYCLES) ? CLEAR_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_GATE   = 3'd2,
    S_SETTLE = 3'd3,
    S_LATCH  = 3'd4,
    S_SHIFT  = 3'd5
  } state_t;

  state_t        state;
  logic [3:0]    mask_q;  // mask copy frozen for the whole round
  logic [CW-1:0] cnt;     // remaining cycles in the current timed state, counts down to 0

  assign state_dbg = state;

  // Index of the lowest enabled oscillator.
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // True when an enabled oscillator with a higher index than cur remains.
  function automatic logic has_next(input logic [3:0] m, input logic [1:0] cur);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m[i] && (i > int'(cur))) r = 1'b1;
    end
    return r;
  endfunction

  // Lowest enabled oscillator index strictly above cur.
  function automatic logic [1:0] next_set(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] r;
    r = cur;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) r = 2'(i);
    end
    return r;
  endfunction

  // Round sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      mask_q         <= 4'd0;
      cnt            <= '0;
      gate           <= 1'b0;
      ctr_reset      <= 1'b0;
      latch_counter  <= 1'b0;
      counter_select <= 2'd0;
      frame_valid    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      round_count    <= 8'd0;
    end else if (ena) begin
      // Single-cycle pulses fall back to 0 unless re-asserted below.
      latch_counter <= 1'b0;
      done          <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        // Abandon the round outright: no done pulse, round_count untouched.
        state       <= S_IDLE;
        gate        <= 1'b0;
        ctr_reset   <= 1'b0;
        frame_valid <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && (ros_mask != 4'd0)) begin
              mask_q    <= ros_mask;
              ctr_reset <= 1'b1;
              busy      <= 1'b1;
              cnt       <= CW'(CLEAR_CYCLES - 1);
              state     <= S_CLEAR;
            end
          end
          S_CLEAR: begin
            if (cnt == '0) begin
              // ctr_reset drops on the same edge gate rises, so they never overlap.
              ctr_reset <= 1'b0;
              gate      <= 1'b1;
              cnt       <= CW'(GATE_CYCLES - 1);
              state     <= S_GATE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_GATE: begin
            if (cnt == '0) begin
              gate  <= 1'b0;
              cnt   <= CW'(SETTLE_CYCLES - 1);
              state <= S_SETTLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_SETTLE: begin
            if (cnt == '0) begin
              counter_select <= lowest_set(mask_q);
              latch_counter  <= 1'b1;
              state          <= S_LATCH;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_LATCH: begin
            frame_valid <= 1'b1;
            cnt         <= CW'(FRAME_CYCLES - 1);
            state       <= S_SHIFT;
          end
          S_SHIFT: begin
            if (cnt == '0) begin
              frame_valid <= 1'b0;
              if (has_next(mask_q, counter_select)) begin
                // Counters still hold their gated values; just read the next one.
                counter_select <= next_set(mask_q, counter_select);
                latch_counter  <= 1'b1;
                state          <= S_LATCH;
              end else begin
                round_count <= round_count + 8'd1;
                if (continuous && (ros_mask != 4'd0)) begin
                  mask_q    <= ros_mask;
                  ctr_reset <= 1'b1;
                  cnt       <= CW'(CLEAR_CYCLES - 1);
                  state     <= S_CLEAR;
                end else begin
                  done  <= ~continuous;
                  busy  <= 1'b0;
                  state <= S_IDLE;
                end
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fmeas_sequencer.sv
// Testbench for fmeas_sequencer: drives measurement rounds and compares every
// output cycle against a timeline computed from the round timing rules
// (clear / gate / settle windows, then one latch + frame per enabled oscillator).
module tb_fmeas_sequencer;

  localparam int C  = 4;
  localparam int G  = 4096;
  localparam int S  = 16;
  localparam int FL = 24;
  localparam int P  = FL + 1;
  localparam int L0 = C + G + S + 1;

  logic       clk = 1'b0;
  logic       reset, ena, start, abort, continuous;
  logic [3:0] ros_mask;
  logic       gate, ctr_reset, latch_counter, frame_valid, busy, done;
  logic [1:0] counter_select;
  logic [7:0] round_count;
  logic [2:0] state_dbg;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_rc   = 8'd0;
  logic [1:0] exp_q[$];

  fmeas_sequencer dut (
    .clk(clk), .reset(reset), .ena(ena), .start(start), .abort(abort),
    .continuous(continuous), .ros_mask(ros_mask), .gate(gate), .ctr_reset(ctr_reset),
    .latch_counter(latch_counter), .counter_select(counter_select),
    .frame_valid(frame_valid), .busy(busy), .done(done), .round_count(round_count),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // One full round starting at t=0 (the cycle where start, or the continuous
  // restart, is taken). mode 0: ends with done; 1: chains into another round;
  // 2: continuous but mask dropped, ends in IDLE without done.
  task automatic round_check(input logic [3:0] m, input int mode, input int start_at,
                             input int mask_at, input logic [3:0] mask_new, input string name);
    int         mm[8];
    int         first_bad[8];
    string      nm[8];
    int         nb, e, last;
    bit         e_ctr, e_gate, e_latch, e_fv, e_done, in_rd, chk_busy, e_busy;
    logic [1:0] cur_sel;
    logic [7:0] e_rc;
    nm = '{"ctr_reset", "gate", "latch_counter", "counter_select", "frame_valid",
           "busy", "done", "round_count"};
    for (int i = 0; i < 8; i++) begin
      mm[i] = 0;
      first_bad[i] = -1;
    end
    exp_q.delete();
    nb = 0;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) begin
        exp_q.push_back(2'(b));
        nb++;
      end
    end
    e       = L0 + P * nb;
    last    = (mode == 1) ? e - 1 : e + 1;
    cur_sel = 2'd0;
    for (int t = 1; t <= last; t++) begin
      @(negedge clk);
      start = (t == start_at);
      if (t == mask_at) ros_mask = mask_new;
      e_ctr   = (t <= C);
      e_gate  = (t > C) && (t <= C + G);
      in_rd   = (t >= L0) && (t < e);
      e_latch = in_rd && (((t - L0) % P) == 0);
      e_fv    = in_rd && (((t - L0) % P) != 0);
      e_done  = (mode == 0) && (t == e);
      chk_busy = !((t == e) && (mode == 0));
      e_busy  = (t < e);
      e_rc    = (t < e) ? exp_rc : exp_rc + 8'd1;
      if (ctr_reset !== e_ctr) begin mm[0]++; if (first_bad[0] < 0) first_bad[0] = t; end
      if (gate !== e_gate) begin mm[1]++; if (first_bad[1] < 0) first_bad[1] = t; end
      if (latch_counter !== e_latch) begin mm[2]++; if (first_bad[2] < 0) first_bad[2] = t; end
      if (latch_counter === 1'b1) begin
        if (exp_q.size() == 0) begin
          mm[3]++; if (first_bad[3] < 0) first_bad[3] = t;
        end else begin
          cur_sel = exp_q.pop_front();
          if (counter_select !== cur_sel) begin mm[3]++; if (first_bad[3] < 0) first_bad[3] = t; end
        end
      end else if (e_fv && (counter_select !== cur_sel)) begin
        mm[3]++; if (first_bad[3] < 0) first_bad[3] = t;
      end
      if (frame_valid !== e_fv) begin mm[4]++; if (first_bad[4] < 0) first_bad[4] = t; end
      if (chk_busy && (busy !== e_busy)) begin mm[5]++; if (first_bad[5] < 0) first_bad[5] = t; end
      if (done !== e_done) begin mm[6]++; if (first_bad[6] < 0) first_bad[6] = t; end
      if (round_count !== e_rc) begin mm[7]++; if (first_bad[7] < 0) first_bad[7] = t; end
    end
    exp_rc = exp_rc + 8'd1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (mm[i] !== 0)
        $display("FAIL %s %s: %0d bad cycles (first at t=%0d), required 0",
                 name, nm[i], mm[i], first_bad[i]);
      else n_pass++;
    end
    n_checks++;
    if (exp_q.size() !== 0)
      $display("FAIL %s latches_missing: %0d selects never latched, required 0", name, exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; ena = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0; ros_mask = 4'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({gate, ctr_reset, latch_counter, counter_select, frame_valid, busy, done, round_count} !== 15'd0)
      $display("FAIL reset_outputs: got gate=%b ctr=%b latch=%b sel=%0d fv=%b busy=%b done=%b rc=%0d state=%0d, required all 0",
               gate, ctr_reset, latch_counter, counter_select, frame_valid, busy, done, round_count, state_dbg);
    else n_pass++;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({gate, ctr_reset, busy, done, round_count} !== 12'd0)
      $display("FAIL idle_after_reset: busy=%b gate=%b rc=%0d, required 0", busy, gate, round_count);
    else n_pass++;
    exp_rc = 8'd0;
  endtask

  task automatic test_full_mask();
    @(negedge clk);
    ros_mask = 4'b1111; start = 1'b1; continuous = 1'b0;
    // Mask change mid-round must not alter the round.
    round_check(4'b1111, 0, -1, 10, 4'b0000, "full_1111");
    n_checks++;
    if (round_count !== 8'd1) $display("FAIL full_rc: got %0d, required 1", round_count);
    else n_pass++;
  endtask

  task automatic test_sparse_mask();
    @(negedge clk);
    ros_mask = 4'b1010; start = 1'b1;
    // A start pulse during the first frame must be ignored.
    round_check(4'b1010, 0, L0 + 5, -1, 4'b0000, "mask_1010");
  endtask

  task automatic test_zero_mask();
    int toggles;
    toggles = 0;
    @(negedge clk);
    ros_mask = 4'b0000; start = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if ({gate, ctr_reset, latch_counter, frame_valid, busy, done} !== 6'd0) toggles++;
      if (round_count !== exp_rc) toggles++;
    end
    start = 1'b0;
    n_checks++;
    if (toggles !== 0) $display("FAIL zero_mask: %0d active cycles, required 0", toggles);
    else n_pass++;
  endtask

  task automatic test_random_rounds();
    logic [3:0] m;
    for (int r = 0; r < 2; r++) begin
      m = 4'($urandom_range(1, 15));
      @(negedge clk);
      ros_mask = m; start = 1'b1;
      round_check(m, 0, -1, int'($urandom_range(2, 4000)), 4'($urandom_range(0, 15)), "random_round");
    end
  endtask

  task automatic test_abort();
    int bad, after;
    bad = 0; after = 0;
    @(negedge clk);
    ros_mask = 4'b1111; start = 1'b1;
    for (int t = 1; t <= C + 100; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (gate !== ((t > C) ? 1'b1 : 1'b0)) bad++;
      if (ctr_reset !== ((t <= C) ? 1'b1 : 1'b0)) bad++;
      if (busy !== 1'b1) bad++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (bad !== 0) $display("FAIL abort_pre_window: %0d bad cycles, required 0", bad);
    else n_pass++;
    n_checks++;
    if ({gate, ctr_reset, latch_counter, frame_valid, busy} !== 5'd0)
      $display("FAIL abort_next_cycle: gate=%b ctr=%b busy=%b fv=%b, required 0", gate, ctr_reset, busy, frame_valid);
    else n_pass++;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if ({gate, busy, done, latch_counter, frame_valid} !== 5'd0) after++;
      if (round_count !== exp_rc) after++;
    end
    n_checks++;
    if (after !== 0) $display("FAIL abort_stays_idle: %0d bad cycles, required 0", after);
    else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk);
    ros_mask = 4'b1111; start = 1'b1;
    for (int t = 1; t <= L0 + 3; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++;
    if (frame_valid !== 1'b1) $display("FAIL pre_reset_frame: frame_valid=%b, required 1", frame_valid);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({gate, ctr_reset, latch_counter, counter_select, frame_valid, busy, done, round_count} !== 15'd0)
      $display("FAIL reset_mid_shift: sel=%0d fv=%b busy=%b rc=%0d, required all 0",
               counter_select, frame_valid, busy, round_count);
    else n_pass++;
    exp_rc = 8'd0;
  endtask

  task automatic test_continuous();
    @(negedge clk);
    ros_mask = 4'b0001; continuous = 1'b1; start = 1'b1;
    round_check(4'b0001, 1, -1, -1, 4'b0000, "cont_round1");
    round_check(4'b0001, 1, -1, -1, 4'b0000, "cont_round2");
    round_check(4'b0001, 2, -1, 100, 4'b0000, "cont_round3");
    continuous = 1'b0;
    n_checks++;
    if (round_count !== 8'd3) $display("FAIL cont_rc: got %0d, required 3", round_count);
    else n_pass++;
  endtask

  task automatic test_ena_freeze();
    int gate_n, latch_t, done_t, e;
    gate_n = 0; latch_t = -1; done_t = -1;
    e = L0 + P;
    @(negedge clk);
    ros_mask = 4'b0001; start = 1'b1;
    for (int t = 1; t <= e + 51; t++) begin
      @(negedge clk);
      start = 1'b0;
      ena = ((t >= C + 200) && (t < C + 250)) ? 1'b0 : 1'b1;
      if (gate === 1'b1) gate_n++;
      if ((latch_counter === 1'b1) && (latch_t < 0)) latch_t = t;
      if ((done === 1'b1) && (done_t < 0)) done_t = t;
    end
    ena = 1'b1;
    exp_rc = exp_rc + 8'd1;
    n_checks++;
    if (gate_n !== G + 50) $display("FAIL ena_gate_len: got %0d cycles, required %0d", gate_n, G + 50);
    else n_pass++;
    n_checks++;
    if (latch_t !== L0 + 50) $display("FAIL ena_latch_time: got t=%0d, required t=%0d", latch_t, L0 + 50);
    else n_pass++;
    n_checks++;
    if (done_t !== e + 50) $display("FAIL ena_done_time: got t=%0d, required t=%0d", done_t, e + 50);
    else n_pass++;
    n_checks++;
    if (round_count !== exp_rc) $display("FAIL ena_rc: got %0d, required %0d", round_count, exp_rc);
    else n_pass++;
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_zero_mask();
    test_random_rounds();
    test_abort();
    test_reset_mid_shift();
    test_continuous();
    test_ena_freeze();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
